// File: rtl/sr_latch_driver_if.sv
// Command/status bundle between the control logic and sr_latch_driver.
// The master side issues set/clear commands; the slave side reports completion and latch state.
interface sr_latch_driver_if;
    logic cmd_valid;
    logic cmd_set;
    logic cmd_ready;
    logic done;
    logic err;
    logic err_sticky;
    logic latch_q;

    modport master (
        output cmd_valid,
        output cmd_set,
        input  cmd_ready,
        input  done,
        input  err,
        input  err_sticky,
        input  latch_q
    );

    modport slave (
        input  cmd_valid,
        input  cmd_set,
        output cmd_ready,
        output done,
        output err,
        output err_sticky,
        output latch_q
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Writes a NAND SR latch from the clocked domain with timed, non-overlapping active-low
// pulses, then reads it back through 2-flop synchronizers and flags any mismatch.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command transfer
// PULSE | s_n (set) or r_n (clear) held low, counter running
// GUARD | both latch inputs high while the read-back settles
// CHECK | done pulse, err reflects the synchronized read-back
module sr_latch_driver #(
    parameter int PULSE_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   cmd,
    output logic               s_n,
    output logic               r_n,
    input  logic               q_fb,
    input  logic               qn_fb
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       exp_q;
    logic       exp_q_nxt;
    logic       q_s1;
    logic       q_s2;
    logic       qn_s1;
    logic       qn_s2;
    logic       s_n_nxt;
    logic       r_n_nxt;
    logic       done_nxt;
    logic       err_nxt;
    logic       ready_nxt;
    logic       cmd_ready_q;
    logic       done_q;
    logic       err_q;
    logic       err_sticky_q;
    logic       xfer;
    logic       drive_pulse;

    assign xfer = cmd.cmd_valid && cmd_ready_q;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        exp_q_nxt   = exp_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        drive_pulse = 1'b0;
        s_n_nxt     = 1'b1;
        r_n_nxt     = 1'b1;
        ready_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    exp_q_nxt = cmd.cmd_set;
                    cnt_nxt   = PULSE_LOAD;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (cnt == 8'd0) begin
                    cnt_nxt   = GUARD_LOAD;
                    state_nxt = GUARD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GUARD: begin
                if (cnt == 8'd0) begin
                    state_nxt = CHECK;
                    done_nxt  = 1'b1;
                    err_nxt   = (q_s2 != exp_q) || (q_s2 == qn_s2);
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Both pulse outputs derive from one decode, so they can never be low together.
        drive_pulse = (state_nxt == PULSE);
        s_n_nxt     = !(drive_pulse && exp_q_nxt);
        r_n_nxt     = !(drive_pulse && !exp_q_nxt);
        ready_nxt   = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            exp_q        <= 1'b0;
            s_n          <= 1'b1;
            r_n          <= 1'b1;
            cmd_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            q_s1         <= 1'b0;
            q_s2         <= 1'b0;
            qn_s1        <= 1'b0;
            qn_s2        <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            exp_q        <= exp_q_nxt;
            s_n          <= s_n_nxt;
            r_n          <= r_n_nxt;
            cmd_ready_q  <= ready_nxt;
            done_q       <= done_nxt;
            err_q        <= err_nxt;
            err_sticky_q <= err_sticky_q | err_nxt;
            q_s1         <= q_fb;
            q_s2         <= q_s1;
            qn_s1        <= qn_fb;
            qn_s2        <= qn_s1;
        end
    end

    assign cmd.cmd_ready  = cmd_ready_q;
    assign cmd.done       = done_q;
    assign cmd.err        = err_q;
    assign cmd.err_sticky = err_sticky_q;
    assign cmd.latch_q    = q_s2;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: a default-timing instance and a PULSE=1/GUARD=2
// instance, each driving a behavioural NAND SR latch model.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_latch_driver_if ifa ();
    sr_latch_driver_if ifb ();

    logic s_n_a, r_n_a, q_a, qn_a;
    logic s_n_b, r_n_b, q_b, qn_b;
    logic stuck = 1'b0;
    logic lq_a = 1'b0;
    logic lq_b = 1'b0;
    logic overlap = 1'b0;
    logic sel = 1'b0;

    int checks = 0;
    int errors = 0;

    sr_latch_driver dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (ifa),
        .s_n   (s_n_a),
        .r_n   (r_n_a),
        .q_fb  (q_a),
        .qn_fb (qn_a)
    );

    sr_latch_driver #(.PULSE_CYCLES(1), .GUARD_CYCLES(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (ifb),
        .s_n   (s_n_b),
        .r_n   (r_n_b),
        .q_fb  (q_b),
        .qn_fb (qn_b)
    );

    // Latch models: set dominates only because overlap is itself flagged below.
    always @(s_n_a or r_n_a) begin
        if (!s_n_a) lq_a = 1'b1;
        else if (!r_n_a) lq_a = 1'b0;
    end
    always @(s_n_b or r_n_b) begin
        if (!s_n_b) lq_b = 1'b1;
        else if (!r_n_b) lq_b = 1'b0;
    end
    assign q_a  = stuck ? 1'b0 : lq_a;
    assign qn_a = ~q_a;
    assign q_b  = lq_b;
    assign qn_b = ~q_b;

    always @(negedge clk) begin
        if ((!s_n_a && !r_n_a) || (!s_n_b && !r_n_b)) overlap = 1'b1;
        assert ((s_n_a || r_n_a) && (s_n_b || r_n_b));
    end

    wire m_s_n   = sel ? s_n_b         : s_n_a;
    wire m_r_n   = sel ? r_n_b         : r_n_a;
    wire m_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
    wire m_done  = sel ? ifb.done      : ifa.done;
    wire m_err   = sel ? ifb.err       : ifa.err;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge with cmd_ready high; returns at the negedge where
    // cmd_ready is high again so commands can run back to back at the minimum period.
    task automatic run_cmd(input bit b, input bit v, input int p, input int g,
                           input int exp_err, input string tag);
        int ns = 0;
        int nr = 0;
        int first_low = -1;
        int done_at = -1;
        int done_n = 0;
        int err_at = -1;
        int rdy_low = 0;
        int rdy_end = 0;
        sel = b;
        if (b) begin ifb.cmd_set = v; ifb.cmd_valid = 1'b1; end
        else   begin ifa.cmd_set = v; ifa.cmd_valid = 1'b1; end
        @(negedge clk);
        if (b) ifb.cmd_valid = 1'b0; else ifa.cmd_valid = 1'b0;
        for (int i = 1; i <= p + g + 2; i++) begin
            if ((!m_s_n || !m_r_n) && first_low < 0) first_low = i;
            if (!m_s_n) ns++;
            if (!m_r_n) nr++;
            if (m_done) begin done_n++; done_at = i; err_at = int'(m_err); end
            if (i <= p + g + 1) begin
                if (!m_ready) rdy_low++;
            end else begin
                rdy_end = int'(m_ready);
            end
            if (i < p + g + 2) @(negedge clk);
        end
        chk({tag, ":pulse_len"}, v ? ns : nr, p);
        chk({tag, ":other_pin_low"}, v ? nr : ns, 0);
        chk({tag, ":pulse_start"}, first_low, 1);
        chk({tag, ":done_at"}, done_at, p + g + 1);
        chk({tag, ":done_count"}, done_n, 1);
        chk({tag, ":err"}, err_at, exp_err);
        chk({tag, ":ready_low"}, rdy_low, p + g + 1);
        chk({tag, ":ready_back"}, rdy_end, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int nx, bad, last, nd, ne, dn;
        bit flip;
        ifa.cmd_valid = 1'b0; ifa.cmd_set = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_set = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst:s_n", s_n_a, 1);
        chk("rst:r_n", r_n_a, 1);
        chk("rst:ready", ifa.cmd_ready, 0);
        chk("rst:done", ifa.done, 0);
        chk("rst:err", ifa.err, 0);
        chk("rst:sticky", ifa.err_sticky, 0);
        chk("rst:latch_q", ifa.latch_q, 0);
        chk("rst:ready_b", ifb.cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst:ready", ifa.cmd_ready, 1);

        run_cmd(0, 1'b1, 4, 2, 0, "set");
        chk("set:latch_q", ifa.latch_q, 1);
        run_cmd(0, 1'b0, 4, 2, 0, "clr");
        chk("clr:latch_q", ifa.latch_q, 0);
        run_cmd(0, 1'b0, 4, 2, 0, "clr_again");
        chk("clr_again:latch_q", ifa.latch_q, 0);
        chk("clr_again:sticky", ifa.err_sticky, 0);

        stuck = 1'b1;
        run_cmd(0, 1'b1, 4, 2, 1, "stuck");
        chk("stuck:sticky", ifa.err_sticky, 1);
        stuck = 1'b0;
        run_cmd(0, 1'b0, 4, 2, 0, "recover");
        chk("recover:sticky", ifa.err_sticky, 1);
        chk("recover:latch_q", ifa.latch_q, 0);

        // Continuous valid, alternating set/clear starting with set.
        ifa.cmd_set = 1'b1; ifa.cmd_valid = 1'b1;
        nx = 0; bad = 0; last = -1; nd = 0; ne = 0; flip = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (flip) begin ifa.cmd_set = ~ifa.cmd_set; flip = 1'b0; end
            if (ifa.cmd_ready) begin
                nx++;
                if (last >= 0 && i - last != 8) bad++;
                last = i;
                flip = 1'b1;
            end
            if (ifa.done) begin nd++; if (ifa.err) ne++; end
            @(negedge clk);
        end
        ifa.cmd_valid = 1'b0;
        chk("stream:transfers", nx, 5);
        chk("stream:bad_period", bad, 0);
        chk("stream:dones", nd, 5);
        chk("stream:errs", ne, 0);
        chk("stream:latch_q", ifa.latch_q, 1);

        // Reset during the second pulse cycle.
        ifa.cmd_set = 1'b1; ifa.cmd_valid = 1'b1;
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        chk("midrst:pulse_on", s_n_a, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst:s_n", s_n_a, 1);
        chk("midrst:r_n", r_n_a, 1);
        chk("midrst:ready", ifa.cmd_ready, 0);
        chk("midrst:done", ifa.done, 0);
        chk("midrst:err", ifa.err, 0);
        chk("midrst:sticky", ifa.err_sticky, 0);
        chk("midrst:latch_q", ifa.latch_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (ifa.done) dn++;
        end
        chk("midrst:no_done", dn, 0);
        chk("midrst:ready_back", ifa.cmd_ready, 1);
        chk("midrst:latch_q_resync", ifa.latch_q, 1);

        run_cmd(1, 1'b1, 1, 2, 0, "short_set");
        chk("short_set:latch_q", ifb.latch_q, 1);
        run_cmd(1, 1'b0, 1, 2, 0, "short_clr");
        chk("short_clr:latch_q", ifb.latch_q, 0);

        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
